uart_rx_os: RTL

- Oversampling UART receiver. Sits directly downstream of the mod-m baud tick generator and consumes its max_tick as the sample strobe s_tick, at 16 ticks per bit.
- Detects the start bit, samples each data bit LSB-first at mid-bit, and checks the stop bit.
- Presents the received word with a one-cycle done pulse to the downstream FIFO/interface.

---
 rtl/uart_rx_os.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 16 s_ticks per bit, mid-bit sampling, LSB first.
// Optional even-parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  localparam logic [2:0] NLAST = 3'(DBIT - 1);
  localparam logic [5:0] SLAST = 6'(SB_TICK - 1);

  state_t          state, state_n;
  logic [5:0]      s, s_n;
  logic [2:0]      n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            sync1, rx_s;
  logic            done;
`ifdef UART_RX_PARITY_EN
  logic            p, p_n;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
`ifdef UART_RX_PARITY_EN
      p     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
`ifdef UART_RX_PARITY_EN
      p     <= p_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_n     = p;
`endif
    unique case (state)
      IDLE: begin
        // start detect runs every clk, not only on s_tick
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == 6'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == 6'd15) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            if (n == NLAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + 3'd1;
            end
          end else begin
            s_n = s + 6'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == 6'd15) begin
            p_n     = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s + 6'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == SLAST) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            s_n = s + 6'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= done;
      if (done) begin
        dout      <= b;
        frame_err <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else if (done) parity_err <= (^b) ^ p;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
